// File: rtl/sram_if_pkg.sv
// ---------------------------------------------------------------------------
// sram_if_pkg
// Shared types for the data_sram slave: access-size encodings and the
// response-queue entry layout. It has no ports; data_sram_slave and
// resp_fifo import it.
// ---------------------------------------------------------------------------
package sram_if_pkg;

    // Access size as driven on data_sram_size. The slave does not act on it;
    // the byte strobes alone decide which lanes are written.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam int CNT_WIDTH = 4;

    // One pending response: kind, captured read data, cycles left to wait.
    typedef struct packed {
        logic                 is_wr;
        logic [31:0]          data;
        logic [CNT_WIDTH-1:0] cnt;
    } resp_entry_t;

endpackage

// File: rtl/data_sram_slave_if.sv
// ---------------------------------------------------------------------------
// data_sram_slave_if
// Bundle of the data_sram request/response signals between a requester
// (master) and the memory stand-in (slave).
//   request : data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
//             data_sram_addr, data_sram_wdata        (master -> slave)
//   response: data_sram_addr_ok, data_sram_data_ok,
//             data_sram_rdata                        (slave -> master)
// ---------------------------------------------------------------------------
interface data_sram_slave_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
               data_sram_wstrb, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
// In-order circular queue of pending responses. Each valid entry's wait
// counter counts down once per cycle until it reaches zero; the head
// retires when its counter is zero and the parent asserts pop.
//   clk, resetn     : clock, synchronous active-low reset
//   push/push_entry : enqueue one entry at the tail
//   pop             : dequeue the head
//   full            : DEPTH entries held
//   head_valid      : queue is non-empty
//   head_entry      : contents of the head slot
// ---------------------------------------------------------------------------
module resp_fifo
    import sram_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        head_valid,
    output resp_entry_t head_entry
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    resp_entry_t      q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;

    assign full       = (count == FULL_COUNT);
    assign head_valid = (count != '0);
    assign head_entry = q[head];

    // Later assignments win: the countdown runs first, then a pop frees the
    // head slot, then a push may refill that same slot when the queue is full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && (q[i].cnt != '0)) begin
                    q[i].cnt <= q[i].cnt - 1'b1;
                end
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (push) begin
                q[tail]     <= push_entry;
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/data_sram_slave.sv
// ---------------------------------------------------------------------------
// data_sram_slave
// Memory stand-in for the CPU data port. Accepts one request per cycle,
// applies byte-strobed writes to a 2^ADDR_WIDTH x 32 word array at
// acceptance, and returns in-order data_ok/rdata LATENCY cycles later.
// Up to DEPTH transactions may be outstanding.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : data_sram_slave_if slave side (request in, response out)
// ---------------------------------------------------------------------------
module data_sram_slave
    import sram_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input logic               clk,
    input logic               resetn,
    data_sram_slave_if.slave  bus
);
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  full;
    logic                  head_valid;
    logic                  pop;
    logic                  accept;
    resp_entry_t           head_entry;
    resp_entry_t           push_entry;

    // Address bits above the word index alias; size is advisory only.
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_WIDTH+2],
                           bus.data_sram_addr[1:0]};

    assign word_idx = bus.data_sram_addr[ADDR_WIDTH+1:2];

    // A retiring head frees a slot on the same edge, so a full queue can
    // still accept.
    assign pop    = head_valid && (head_entry.cnt == '0);
    assign accept = resetn && bus.data_sram_req && (!full || pop);

    assign bus.data_sram_addr_ok = accept;
    assign bus.data_sram_data_ok = resetn && pop;
    assign bus.data_sram_rdata   = (resetn && pop && !head_entry.is_wr) ? head_entry.data : 32'h0;

    // Only one request is accepted per edge, so the array read for a read
    // request already reflects every earlier write.
    always_comb begin
        push_entry       = '0;
        push_entry.is_wr = bus.data_sram_wr;
        push_entry.data  = bus.data_sram_wr ? 32'h0 : mem[word_idx];
        push_entry.cnt   = CNT_WIDTH'(LATENCY - 1);
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    resp_fifo #(.DEPTH(DEPTH)) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .head_valid (head_valid),
        .head_entry (head_entry)
    );
endmodule

// File: tb/tb_data_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_data_sram_slave
// Directed bench for data_sram_slave. Two instances share clk/resetn:
// dut_a (LATENCY=2, DEPTH=4) and dut_b (LATENCY=8, DEPTH=4). Inputs change
// 1 time unit after each rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_data_sram_slave;

    logic clk = 1'b0;
    logic resetn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    data_sram_slave_if bus_a ();
    data_sram_slave_if bus_b ();

    data_sram_slave #(.ADDR_WIDTH(12), .LATENCY(2), .DEPTH(4)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    data_sram_slave #(.ADDR_WIDTH(12), .LATENCY(8), .DEPTH(4)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request on the selected instance; the other one idles.
    task automatic applyStimulus(input int which, input logic req, input logic wr,
                                 input logic [3:0] wstrb, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        bus_a.data_sram_req   = 1'b0;
        bus_a.data_sram_wr    = 1'b0;
        bus_a.data_sram_size  = 2'd2;
        bus_a.data_sram_wstrb = 4'h0;
        bus_a.data_sram_addr  = 32'h0;
        bus_a.data_sram_wdata = 32'h0;
        bus_b.data_sram_req   = 1'b0;
        bus_b.data_sram_wr    = 1'b0;
        bus_b.data_sram_size  = 2'd2;
        bus_b.data_sram_wstrb = 4'h0;
        bus_b.data_sram_addr  = 32'h0;
        bus_b.data_sram_wdata = 32'h0;
        if (which == 0) begin
            bus_a.data_sram_req   = req;
            bus_a.data_sram_wr    = wr;
            bus_a.data_sram_wstrb = wstrb;
            bus_a.data_sram_addr  = addr;
            bus_a.data_sram_wdata = wdata;
        end else begin
            bus_b.data_sram_req   = req;
            bus_b.data_sram_wr    = wr;
            bus_b.data_sram_wstrb = wstrb;
            bus_b.data_sram_addr  = addr;
            bus_b.data_sram_wdata = wdata;
        end
    endtask

    // One clock cycle: drive, sample at the falling edge, advance past the edge.
    task automatic doStep(input int which, input logic req, input logic wr,
                          input logic [3:0] wstrb, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_aok,
                          input logic exp_dok, input logic [31:0] exp_rdata,
                          input string tag);
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        applyStimulus(which, req, wr, wstrb, addr, wdata);
        @(negedge clk);
        if (which == 0) begin
            aok   = bus_a.data_sram_addr_ok;
            dok   = bus_a.data_sram_data_ok;
            rdata = bus_a.data_sram_rdata;
        end else begin
            aok   = bus_b.data_sram_addr_ok;
            dok   = bus_b.data_sram_data_ok;
            rdata = bus_b.data_sram_rdata;
        end
        checkOutput({tag, " addr_ok"}, {31'h0, aok}, {31'h0, exp_aok});
        checkOutput({tag, " data_ok"}, {31'h0, dok}, {31'h0, exp_dok});
        if (exp_dok) begin
            checkOutput({tag, " rdata"}, rdata, exp_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a request pending: nothing may be accepted or returned.
        resetn = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset a addr_ok", {31'h0, bus_a.data_sram_addr_ok}, 32'h0);
        checkOutput("reset a data_ok", {31'h0, bus_a.data_sram_data_ok}, 32'h0);
        checkOutput("reset a rdata",   bus_a.data_sram_rdata, 32'h0);
        checkOutput("reset b data_ok", {31'h0, bus_b.data_sram_data_ok}, 32'h0);
        @(posedge clk);
        #1;
        doStep(1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "reset b");
        resetn = 1'b1;

        // Single write then read, LATENCY=2.
        doStep(0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, "wr_rd s0");
        doStep(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h0, "wr_rd s1");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0, "wr_rd s2");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF, "wr_rd s3");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0, "wr_rd s4");

        // Byte strobes: only lane 2 of the second write lands.
        doStep(0, 1'b1, 1'b1, 4'hF,    32'h20, 32'h11223344, 1'b1, 1'b0, 32'h0, "strb s0");
        doStep(0, 1'b1, 1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA, 1'b1, 1'b0, 32'h0, "strb s1");
        doStep(0, 1'b1, 1'b0, 4'h0,    32'h20, 32'h0,        1'b1, 1'b1, 32'h0, "strb s2");
        doStep(0, 1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b1, 32'h0, "strb s3");
        doStep(0, 1'b0, 1'b0, 4'h0,    32'h0,  32'h0,        1'b0, 1'b1, 32'h11AA3344, "strb s4");

        // Read on the edge right after the write to the same word; the
        // upper address bits alias onto word 0x40.
        doStep(0, 1'b1, 1'b1, 4'hF, 32'h40,     32'h5, 1'b1, 1'b0, 32'h0, "raw s0");
        doStep(0, 1'b1, 1'b0, 4'h0, 32'hF000_4040 & 32'hF000_0040, 32'h0, 1'b1, 1'b0, 32'h0, "raw s1");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,      32'h0, 1'b0, 1'b1, 32'h0, "raw s2");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,      32'h0, 1'b0, 1'b1, 32'h5, "raw s3");
        doStep(0, 1'b0, 1'b0, 4'h0, 32'h0,      32'h0, 1'b0, 1'b0, 32'h0, "raw s4");

        // Streaming: 8 writes then 8 reads on consecutive cycles.
        for (int s = 0; s < 19; s++) begin
            logic        rq;
            logic        wr;
            logic        dok;
            logic [31:0] rexp;
            rq   = (s < 16);
            wr   = (s < 8);
            dok  = (s >= 2) && (s < 18);
            rexp = (s >= 10) ? (32'hC0DE0000 + 32'(s - 10)) : 32'h0;
            doStep(0, rq, wr, 4'hF, 32'h200 + 32'(4 * (s % 8)), 32'hC0DE0000 + 32'(s),
                   rq, dok, rexp, $sformatf("stream s%0d", s));
        end

        // Full queue on dut_b (LATENCY=8, DEPTH=4): req held high for 20
        // cycles, then drained.
        for (int s = 0; s < 29; s++) begin
            logic rq;
            logic aok;
            logic dok;
            rq  = (s < 20);
            aok = rq && ((s % 8) < 4);
            dok = (s >= 8) && ((s % 8) < 4);
            doStep(1, rq, 1'b1, 4'h0, 32'h500, 32'h0, aok, dok, 32'h0,
                   $sformatf("full s%0d", s));
        end

        // Reset mid-flight on dut_b: 3 reads outstanding are discarded.
        doStep(1, 1'b1, 1'b1, 4'hF, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'h0, "midrst w");
        for (int s = 0; s < 3; s++) begin
            doStep(1, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0,
                   $sformatf("midrst rd%0d", s));
        end
        resetn = 1'b0;
        doStep(1, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, "midrst in_reset");
        resetn = 1'b1;
        for (int s = 0; s < 12; s++) begin
            doStep(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                   $sformatf("midrst idle%0d", s));
        end
        doStep(1, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, "postrst rd");
        for (int s = 1; s < 8; s++) begin
            doStep(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                   $sformatf("postrst wait%0d", s));
        end
        doStep(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12345678, "postrst resp");
        doStep(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "postrst done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
